// File: rtl/tx_buf_ctrl.sv
// Circular-FIFO controller between the core output path and uart_tx, sequencing the tx_buf byte RAM.
// Pushes write at wr_ptr; pending bytes are popped one at a time, started with a one-cycle pulse and awaited.
module tx_buf_ctrl #(
   parameter int ADDR_W = 20,
   parameter int DEPTH  = 200001
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [7:0]        push_data,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic [ADDR_W-1:0] count,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_wa,
   output logic [7:0]        buf_wd,
   output logic [ADDR_W-1:0] buf_ra,
   input  logic [7:0]        buf_rd,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy
);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [15:0]       guard;
   logic              pop;

   // full is taken from the registered count, so a push while full is dropped even if a pop coincides
   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign buf_we = push & ~full;
   assign buf_wa = wr_ptr;
   assign buf_wd = push_data;
   assign buf_ra = rd_ptr;
   assign pop    = (state == IDLE) && !empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!empty) state_nxt = START;
         START:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (tx_busy || guard == 16'hFFFE) state_nxt = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state == START);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_data  <= 8'h00;
         guard    <= 16'h0000;
      end else begin
         if (buf_we) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (push && full) overflow <= 1'b1;
         if (pop) begin
            tx_data <= buf_rd;
            rd_ptr  <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         end
         count <= count + ADDR_W'(buf_we) - ADDR_W'(pop);
         // Counts cycles spent waiting for uart_tx to acknowledge the start pulse
         if (state == WAIT_BUSY) guard <= guard + 16'h0001;
         else                    guard <= 16'h0000;
      end
   end

endmodule
